// File: rtl/rv_instr_stream_checker_if.sv
// Fetch->decode instruction handshake bundle for rv_instr_stream_checker.
// The checker only observes the bus, so it binds through the monitor modport.
interface rv_instr_stream_checker_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master  (output instr_valid, output instr, input instr_ready);
    modport slave   (input instr_valid, input instr, output instr_ready);
    modport monitor (input instr_valid, input instr_ready, input instr);
endinterface

// File: rtl/rv_instr_stream_checker.sv
// RV32IMA fetch->decode stream checker: legality decode, handshake protocol, stall watchdog, statistics.
// Optional first-illegal capture outputs are enabled with `define RV_INSTR_CHK_CAPTURE_EN.
module rv_instr_stream_checker #(
    parameter bit EN_M        = 1'b1,
    parameter bit EN_A        = 1'b1,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    rv_instr_stream_checker_if.monitor   bus,
    output logic                         illegal_o,
    output logic [CNT_W-1:0]             illegal_cnt,
    output logic [CNT_W-1:0]             accept_cnt,
    output logic                         proto_err,
    output logic                         stall_err,
    output logic                         busy
`ifdef RV_INSTR_CHK_CAPTURE_EN
    ,
    output logic [31:0]                  first_bad_instr,
    output logic [CNT_W-1:0]             first_bad_idx
`endif
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // Full RV32IMA field decode; returns 1 when the word is a legal instruction.
    function automatic logic legal_f(input logic [31:0] w);
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] f5;
        f3 = w[14:12];
        f7 = w[31:25];
        f5 = w[31:27];
        ok = 1'b0;
        case (w[6:0])
            7'b0000011: ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            7'b0100011: ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            7'b1100011: ok = (f3 != 3'b010) && (f3 != 3'b011);
            7'b1100111: ok = (f3 == 3'b000);
            7'b0110111, 7'b0010111, 7'b1101111: ok = 1'b1;
            7'b0010011: begin
                case (f3)
                    3'b001:  ok = (f7 == 7'b0000000);
                    3'b101:  ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: ok = 1'b1;
                endcase
            end
            7'b0110011: begin
                case (f7)
                    7'b0000000: ok = 1'b1;
                    7'b0100000: ok = (f3 == 3'b000) || (f3 == 3'b101);
                    7'b0000001: ok = EN_M;
                    default:    ok = 1'b0;
                endcase
            end
            7'b0101111: begin
                if (EN_A && (f3 == 3'b010)) begin
                    case (f5)
                        5'b00010: ok = (w[24:20] == 5'b00000);
                        5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
                        5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: ok = 1'b1;
                        default:  ok = 1'b0;
                    endcase
                end else begin
                    ok = 1'b0;
                end
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_r;
    logic [31:0]      held_r;
    logic [CNT_W-1:0] stall_r;

    logic             accept_s;
    logic             wait_s;
    logic             legal_s;
    logic [CNT_W-1:0] stall_nxt_s;
    logic [CNT_W-1:0] acc_nxt_s;
    logic [CNT_W-1:0] ill_nxt_s;

    assign accept_s = bus.instr_valid & bus.instr_ready;
    assign wait_s   = bus.instr_valid & ~bus.instr_ready;
    assign legal_s  = legal_f(bus.instr);

    // Saturating next values for the stall counter and the statistics counters.
    always_comb begin
        stall_nxt_s = stall_r;
        acc_nxt_s   = accept_cnt;
        ill_nxt_s   = illegal_cnt;
        if (state_r == IDLE) begin
            stall_nxt_s = ONE;
        end else if (stall_r != CNT_MAX) begin
            stall_nxt_s = stall_r + ONE;
        end else begin
            stall_nxt_s = stall_r;
        end
        if (accept_cnt != CNT_MAX) begin
            acc_nxt_s = accept_cnt + ONE;
        end else begin
            acc_nxt_s = accept_cnt;
        end
        if (illegal_cnt != CNT_MAX) begin
            ill_nxt_s = illegal_cnt + ONE;
        end else begin
            ill_nxt_s = illegal_cnt;
        end
    end

    // Handshake FSM with held word, stall watchdog and sticky protocol flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            held_r    <= 32'h0000_0000;
            stall_r   <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            stall_err <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (wait_s) begin
                        state_r <= PENDING;
                        held_r  <= bus.instr;
                        stall_r <= stall_nxt_s;
                        busy    <= 1'b1;
                        if (stall_nxt_s >= LIMIT) stall_err <= 1'b1;
                    end else begin
                        stall_r <= '0;
                        busy    <= 1'b0;
                    end
                end
                PENDING: begin
                    if (!bus.instr_valid) begin
                        proto_err <= 1'b1;
                        state_r   <= IDLE;
                        stall_r   <= '0;
                        busy      <= 1'b0;
                    end else begin
                        if (bus.instr != held_r) proto_err <= 1'b1;
                        if (bus.instr_ready) begin
                            state_r <= IDLE;
                            stall_r <= '0;
                            busy    <= 1'b0;
                        end else begin
                            held_r  <= bus.instr;
                            stall_r <= stall_nxt_s;
                            busy    <= 1'b1;
                            if (stall_nxt_s >= LIMIT) stall_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    stall_r <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Accept statistics and the one-cycle illegal pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_o   <= 1'b0;
            accept_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (accept_s) begin
            illegal_o  <= ~legal_s;
            accept_cnt <= acc_nxt_s;
            if (!legal_s) illegal_cnt <= ill_nxt_s;
        end else begin
            illegal_o <= 1'b0;
        end
    end

`ifdef RV_INSTR_CHK_CAPTURE_EN
    logic captured_r;

    // First illegal accepted word; the index is the accept count including that accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            captured_r      <= 1'b0;
            first_bad_instr <= 32'h0000_0000;
            first_bad_idx   <= '0;
        end else if (accept_s && !legal_s && !captured_r) begin
            captured_r      <= 1'b1;
            first_bad_instr <= bus.instr;
            first_bad_idx   <= acc_nxt_s;
        end else begin
            captured_r <= captured_r;
        end
    end
`endif

endmodule

// File: tb/tb_rv_instr_stream_checker.sv
// Scoreboard bench for rv_instr_stream_checker: instance A with default parameters,
// instance B with EN_M=0, EN_A=0, STALL_LIMIT=4, CNT_W=4, both observing the same bus.
module tb_rv_instr_stream_checker;

    logic clk;
    logic reset;

    rv_instr_stream_checker_if bus ();

    logic        ill_a, proto_a, stall_a, busy_a;
    logic [15:0] icnt_a, acnt_a;
    logic        ill_b, proto_b, stall_b, busy_b;
    logic [3:0]  icnt_b, acnt_b;
`ifdef RV_INSTR_CHK_CAPTURE_EN
    logic [31:0] fbi_a, fbi_b;
    logic [15:0] fbx_a;
    logic [3:0]  fbx_b;
`endif

    rv_instr_stream_checker dut_a (
        .clk(clk), .reset(reset), .bus(bus),
        .illegal_o(ill_a), .illegal_cnt(icnt_a), .accept_cnt(acnt_a),
        .proto_err(proto_a), .stall_err(stall_a), .busy(busy_a)
`ifdef RV_INSTR_CHK_CAPTURE_EN
        , .first_bad_instr(fbi_a), .first_bad_idx(fbx_a)
`endif
    );

    rv_instr_stream_checker #(.EN_M(1'b0), .EN_A(1'b0), .STALL_LIMIT(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus),
        .illegal_o(ill_b), .illegal_cnt(icnt_b), .accept_cnt(acnt_b),
        .proto_err(proto_b), .stall_err(stall_b), .busy(busy_b)
`ifdef RV_INSTR_CHK_CAPTURE_EN
        , .first_bad_instr(fbi_b), .first_bad_idx(fbx_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic ia; logic ib; } exp_t;
    typedef struct { logic [31:0] w; logic la; logic lb; } vec_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   errs   = 0;
    int   checks = 0;
    int   exp_acc_a, exp_ill_a, exp_acc_b, exp_ill_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [31:0] w, input logic la, input logic lb);
        vec_t v;
        v.w = w; v.la = la; v.lb = lb;
        tbl.push_back(v);
    endtask

    // One clock: drive at negedge, predict on accept, compare at the following negedge.
    task automatic drive(input logic v, input logic r, input logic [31:0] w,
                         input logic la, input logic lb);
        exp_t e;
        bus.instr_valid = v;
        bus.instr_ready = r;
        bus.instr       = w;
        if (v && r) begin
            if (exp_acc_a < 65535) exp_acc_a++;
            if (!la && exp_ill_a < 65535) exp_ill_a++;
            if (exp_acc_b < 15) exp_acc_b++;
            if (!lb && exp_ill_b < 15) exp_ill_b++;
            e.ia = !la; e.ib = !lb;
            sbq.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
        end else begin
            e.ia = 1'b0; e.ib = 1'b0;
        end
        chk("illegal_o_a", ill_a, e.ia);
        chk("illegal_o_b", ill_b, e.ib);
        chk("accept_cnt_a", acnt_a, exp_acc_a);
        chk("illegal_cnt_a", icnt_a, exp_ill_a);
        chk("accept_cnt_b", acnt_b, exp_acc_b);
        chk("illegal_cnt_b", icnt_b, exp_ill_b);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"}, {ill_a, proto_a, stall_a, busy_a, icnt_a, acnt_a}, 32'h0);
        chk({tag, "_b"}, {ill_b, proto_b, stall_b, busy_b, icnt_b, acnt_b}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_ready = 1'b0;
        bus.instr       = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_acc_a = 0; exp_ill_a = 0; exp_acc_b = 0; exp_ill_b = 0;
        sbq.delete();
        chk_zero("reset");
    endtask

    initial begin
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_ready = 1'b0;
        bus.instr       = 32'h0;

        add(32'h0000_0013, 1'b1, 1'b1);  // addi
        add(32'h0220_8033, 1'b1, 1'b0);  // mul
        add(32'h1000_A02F, 1'b1, 1'b0);  // lr.w rs2=0
        add(32'h1010_A02F, 1'b0, 1'b0);  // lr.w rs2=1
        add(32'h0000_202F, 1'b1, 1'b0);  // amoadd.w
        add(32'h0000_302F, 1'b0, 1'b0);  // amo funct3=011
        add(32'h2800_202F, 1'b0, 1'b0);  // amo funct5=00101
        add(32'hFFFF_FFFF, 1'b0, 1'b0);
        add(32'h0000_2003, 1'b1, 1'b1);  // lw
        add(32'h0000_3003, 1'b0, 1'b0);  // ld
        add(32'h0000_2023, 1'b1, 1'b1);  // sw
        add(32'h0000_3023, 1'b0, 1'b0);  // sd
        add(32'h0000_0063, 1'b1, 1'b1);  // beq
        add(32'h0000_2063, 1'b0, 1'b0);  // branch funct3=010
        add(32'h0000_1067, 1'b0, 1'b0);  // jalr funct3=001
        add(32'h0000_0037, 1'b1, 1'b1);  // lui
        add(32'h0000_006F, 1'b1, 1'b1);  // jal
        add(32'h4000_5013, 1'b1, 1'b1);  // srai
        add(32'h4000_1013, 1'b0, 1'b0);  // slli funct7=0100000
        add(32'h4000_0033, 1'b1, 1'b1);  // sub
        add(32'h4000_1033, 1'b0, 1'b0);  // op funct7=0100000 funct3=001
        add(32'h0000_0012, 1'b0, 1'b0);  // low bits 10

        @(negedge clk);
        do_reset();

        // First accept, then the decode table with an idle gap in the middle.
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b1, 1'b1, tbl[i].w, tbl[i].la, tbl[i].lb);
            if (i == 7) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Word changes while pending.
        do_reset();
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        chk("busy_p1", {busy_a, busy_b, proto_a, proto_b}, 4'b1100);
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        chk("busy_p2", {busy_a, busy_b, proto_a, proto_b}, 4'b1100);
        drive(1'b1, 1'b0, 32'h0010_0093, 1'b1, 1'b1);
        chk("proto_change", {busy_a, busy_b, proto_a, proto_b, stall_b}, 5'b11110);
        drive(1'b1, 1'b1, 32'h0010_0093, 1'b1, 1'b1);
        chk("proto_sticky", {busy_a, busy_b, proto_a, proto_b}, 4'b0011);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("proto_hold", {proto_a, proto_b}, 2'b11);

        // Valid dropped while pending.
        do_reset();
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        chk("proto_drop", {busy_a, busy_b, proto_a, proto_b}, 4'b0011);

        // Watchdog on B (limit 4); A stays quiet.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
            chk($sformatf("stall_e%0d", i), {stall_a, stall_b, busy_b}, {1'b0, (i == 4), 1'b1});
        end
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b1);
        chk("stall_sticky", {stall_a, stall_b, proto_a, proto_b, busy_b}, 5'b01000);

        // Saturation on B, then reset while pending.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 32'h0000_007F, 1'b0, 1'b0);
        chk("sat_b", {icnt_b, acnt_b}, 8'hFF);
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b1);
        chk("pend_before_rst", {busy_a, busy_b}, 2'b11);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_acc_a = 0; exp_ill_a = 0; exp_acc_b = 0; exp_ill_b = 0;
        chk_zero("rst_pending");
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("after_rst_pending", {proto_a, proto_b, busy_a, busy_b}, 4'b0000);

`ifdef RV_INSTR_CHK_CAPTURE_EN
        do_reset();
        chk("cap_reset", {fbi_a, fbi_b}, 64'h0);
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'h0000_0013, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'h1000_A02F, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("cap_instr_a", fbi_a, 32'hFFFF_FFFF);
        chk("cap_idx_a", fbx_a, 32'd4);
        chk("cap_instr_b", fbi_b, 32'h1000_A02F);
        chk("cap_idx_b", fbx_b, 32'd3);
        drive(1'b1, 1'b1, 32'h0000_007F, 1'b0, 1'b0);
        chk("cap_hold_a", {fbx_a, fbi_a}, {16'd4, 32'hFFFF_FFFF});
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rv_instr_stream_checker.md
Name: rv_instr_stream_checker

Overview:
- Synthesizable checker on the fetch→decode instruction handshake of the RV32IMA core.
- Extends the fixed base-opcode legality constraint with full field decoding (funct3/funct7/funct5) and extension gating by parameter.
- Adds valid/ready protocol checking, a stall watchdog, and saturating statistics counters.
- Used in simulation benches and as a formal checker via its sticky flags.

Parameters:
- EN_M, 1, accept the M extension (OP with funct7=0000001).
- EN_A, 1, accept the A extension (AMO opcode 0101111).
- STALL_LIMIT, 64, maximum consecutive cycles valid&!ready before stall_err; legal range 1..2^CNT_W-1.
- CNT_W, 16, width of all counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  producer has an instruction.
- instr_ready  in  1  consumer accepts.
- instr  in  32  instruction word.
- illegal_o  out  1  one-cycle pulse, registered, one cycle after an illegal instruction is accepted.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.
- accept_cnt  out  CNT_W  saturating count of all accepted instructions.
- proto_err  out  1  sticky protocol violation.
- stall_err  out  1  sticky watchdog timeout.
- busy  out  1  high while the FSM is in PENDING.

Behaviour:
- Handshake: accept = instr_valid & instr_ready.
- Reset (reset=1 at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - The stall counter, the held word and all counters clear.
  - Reset mid-PENDING discards the pending transfer with no error.
- Legality decode is combinational on instr; its result is registered to illegal_o on accept.
  - LOAD 0000011: funct3 ∈ {000,001,010,100,101}.
  - STORE 0100011: funct3 ∈ {000,001,010}.
  - BRANCH 1100011: funct3 ∉ {010,011}.
  - JALR 1100111: funct3=000.
  - LUI, AUIPC, JAL: always legal.
  - OP-IMM 0010011: funct3=001 needs funct7=0000000; funct3=101 needs funct7 ∈ {0000000,0100000}; all other funct3 legal.
  - OP 0110011:
    - funct7=0000000: any funct3.
    - funct7=0100000: funct3 ∈ {000,101}.
    - funct7=0000001: legal only if EN_M=1.
  - AMO 0101111: only if EN_A=1, and needs funct3=010 and funct5 ∈ {00010,00011,00001,00000,00100,01100,01000,10000,10100,11000,11100}; LR (funct5=00010) additionally needs rs2=0.
  - Any other opcode is illegal. instr[1:0]≠11 is illegal.
- FSM states: IDLE, PENDING.
  - IDLE → PENDING when instr_valid & !instr_ready; latch instr into the held word and set the stall counter to 1.
  - IDLE stays IDLE on accept or no valid.
  - PENDING → IDLE on accept.
  - PENDING stays PENDING while valid & !ready; stall counter increments and saturates.
- Protocol errors (proto_err set next edge, sticky until reset):
  - In PENDING, instr_valid drops before accept.
  - In PENDING, instr differs from the held word.
  - In both cases the FSM returns to IDLE if valid dropped; otherwise it stays PENDING and re-latches the new word.
- Watchdog: when the stall counter reaches STALL_LIMIT while still pending, stall_err sets on that edge and stays sticky until reset.
- Counters:
  - accept_cnt increments on each accept.
  - illegal_cnt increments on each accept whose word is illegal.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Simultaneous accept and a protocol violation in the same cycle: the accept is counted and the violation is flagged.
- Latency: illegal_o and the counters update one cycle after the accept cycle.

Optional Feature:
- Macro: RV_INSTR_CHK_CAPTURE_EN.
- When defined, two extra outputs are added:
  - first_bad_instr (32): the word of the first illegal accepted instruction.
  - first_bad_idx (CNT_W): the accept_cnt value at that accept.
  - Both are captured once, held until reset, and reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then accept 0x00000013 (addi x0,x0,0) with valid=ready=1 → next cycle accept_cnt=1, illegal_cnt=0, illegal_o=0.
- EN_M=0: accept 0x02208033 (mul) → illegal_o=1 for exactly one cycle, illegal_cnt=1. With EN_M=1 the same word is legal.
- Hold valid=1, ready=0 with instr 0x00000013, then change instr to 0x00100093 on the 3rd cycle → proto_err=1 next edge and stays 1; busy=1 throughout.
- STALL_LIMIT=4: valid=1, ready=0 with a stable word → stall_err rises on the 4th pending edge; ready=1 afterwards → accept_cnt=1, stall_err remains 1.
- CNT_W=4: accept 20 illegal words 0x0000007F → illegal_cnt=accept_cnt=15 (saturated); assert reset mid-PENDING → all outputs 0, proto_err=0.
- With RV_INSTR_CHK_CAPTURE_EN: accept legal, legal, then 0x1000A02F (lr.w with rs2≠0 is not used; 0x1000A02F has rs2=0, so it is legal), then 0xFFFFFFFF → first_bad_instr=0xFFFFFFFF, first_bad_idx=4.
